// File: rtl/key_event_if.sv
// Signal bundle between the key-event block and its user: timebase/key inputs and event pulses.
interface key_event_if;
    logic tick;
    logic level;
    logic press;
    logic rel;
    logic long;
    logic rpt;
    logic held;

    modport master (
        output tick,
        output level,
        input  press,
        input  rel,
        input  long,
        input  rpt,
        input  held
    );

    modport slave (
        input  tick,
        input  level,
        output press,
        output rel,
        output long,
        output rpt,
        output held
    );
endinterface

// File: rtl/key_event.sv
// Turns a debounced key level into press / release / long-press / auto-repeat pulses.
// Define KEY_EVENT_REPEAT_EN to enable auto-repeat pulses while in long-press.
module key_event #(
    parameter int unsigned LONG_TICKS = 100,
    parameter int unsigned RPT_TICKS  = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    key_event_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        LONG = 2'd2
    } state_t;

    localparam logic [7:0] LONG_LIM = 8'(LONG_TICKS);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;
    logic       press_q, press_d;
    logic       rel_q, rel_d;
    logic       long_q, long_d;

`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [7:0] RPT_LIM = 8'(RPT_TICKS);
    logic       rpt_q, rpt_d;
`else
    logic [7:0] rpt_ticks_unused;
    assign rpt_ticks_unused = 8'(RPT_TICKS);
`endif

    // cnt stays below its terminal count, so the increment can never wrap
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
        rpt_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.level) begin
                    state_d = DOWN;
                    cnt_d   = 8'd0;
                    press_d = 1'b1;
                end
            end
            DOWN: begin
                // release wins over a coincident tick expiry
                if (!bus.level) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    rel_d   = 1'b1;
                end else if (bus.tick) begin
                    if (cnt_inc == LONG_LIM) begin
                        state_d = LONG;
                        cnt_d   = 8'd0;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            LONG: begin
                if (!bus.level) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    rel_d   = 1'b1;
                end else if (bus.tick) begin
`ifdef KEY_EVENT_REPEAT_EN
                    if (cnt_inc == RPT_LIM) begin
                        cnt_d = 8'd0;
                        rpt_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
`else
                    cnt_d = 8'd0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
        end
    end

`ifdef KEY_EVENT_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q <= 1'b0;
        end else begin
            rpt_q <= rpt_d;
        end
    end

    assign bus.rpt = rpt_q;
`else
    assign bus.rpt = 1'b0;
`endif

    assign bus.press = press_q;
    assign bus.rel   = rel_q;
    assign bus.long  = long_q;
    assign bus.held  = (state_q != IDLE);

endmodule

// File: tb/tb_key_event.sv
// Self-checking bench for key_event: directed scenarios plus random key activity
// compared against a hold-duration model counted in ticks since key-down.
module tb_key_event;

    localparam int LONG_T = 4;
    localparam int RPT_T  = 3;
`ifdef KEY_EVENT_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    logic clk;
    logic rst_n;
    key_event_if bus ();

    key_event #(
        .LONG_TICKS(LONG_T),
        .RPT_TICKS (RPT_T)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int passes;

    // Reference model: whether the key is considered down, and how many ticks
    // have elapsed since key-down. Expected outputs {press,rel,long,rpt,held}.
    bit         m_down;
    int         m_ticks;
    logic [4:0] exp_o;

    function automatic logic [4:0] dut_o();
        return {bus.press, bus.rel, bus.long, bus.rpt, bus.held};
    endfunction

    task automatic model_reset();
        m_down  = 1'b0;
        m_ticks = 0;
        exp_o   = 5'b0;
    endtask

    task automatic model_edge(input logic t, input logic l);
        logic p, r, lg, rp;
        p = 0; r = 0; lg = 0; rp = 0;
        if (!m_down) begin
            if (l) begin
                m_down  = 1'b1;
                m_ticks = 0;
                p       = 1'b1;
            end
        end else if (!l) begin
            m_down = 1'b0;
            r      = 1'b1;
        end else if (t) begin
            m_ticks++;
            if (m_ticks == LONG_T)
                lg = 1'b1;
            else if (REPEAT && m_ticks > LONG_T && ((m_ticks - LONG_T) % RPT_T) == 0)
                rp = 1'b1;
        end
        exp_o = {p, r, lg, rp, m_down};
    endtask

    // Drive inputs shortly after a rising edge, take one edge, sample 1 time unit later.
    task automatic cycle(input logic t, input logic l);
        bus.tick  = t;
        bus.level = l;
        @(posedge clk);
        model_edge(t, l);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.tick  = 1'b0;
        bus.level = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_o() !== 5'b0)
            $display("[TB] FAIL reset_outputs: got %b expected %b", dut_o(), 5'b0);
        else
            passes++;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0);
        checks++;
        if (dut_o() !== exp_o)
            $display("[TB] FAIL idle_ignores_tick: got %b expected %b", dut_o(), exp_o);
        else
            passes++;
    endtask

    task automatic test_reset_level_high();
        rst_n     = 1'b0;
        bus.level = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1);
            checks++;
            if (dut_o() !== exp_o)
                $display("[TB] FAIL reset_level_high[%0d]: got %b expected %b", i, dut_o(), exp_o);
            else
                passes++;
        end
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
    endtask

    task automatic test_long_press();
        int long_seen;
        long_seen = 0;
        cycle(1'b0, 1'b1);
        checks++;
        if (dut_o() !== 5'b10001)
            $display("[TB] FAIL long_press_start: got %b expected %b", dut_o(), 5'b10001);
        else
            passes++;
        for (int k = 1; k <= LONG_T + 1; k++) begin
            for (int j = 0; j < 10; j++) begin
                cycle(j == 9, 1'b1);
                long_seen += bus.long;
                checks++;
                if (dut_o() !== exp_o)
                    $display("[TB] FAIL long_press tick%0d cyc%0d: got %b expected %b", k, j, dut_o(), exp_o);
                else
                    passes++;
            end
        end
        checks++;
        if (long_seen != 1)
            $display("[TB] FAIL long_pulse_count: got %0d expected 1", long_seen);
        else
            passes++;
        cycle(1'b0, 1'b0);
        checks++;
        if (dut_o() !== 5'b01000)
            $display("[TB] FAIL long_press_release: got %b expected %b", dut_o(), 5'b01000);
        else
            passes++;
        cycle(1'b0, 1'b0);
    endtask

    task automatic test_release_on_expiry();
        cycle(1'b0, 1'b1);
        for (int k = 0; k < LONG_T - 1; k++) begin
            cycle(1'b1, 1'b1);
            cycle(1'b0, 1'b1);
        end
        cycle(1'b1, 1'b0);
        checks++;
        if (dut_o() !== 5'b01000 || dut_o() !== exp_o)
            $display("[TB] FAIL release_on_expiry: got %b expected %b", dut_o(), 5'b01000);
        else
            passes++;
        for (int j = 0; j < 3; j++) begin
            cycle(1'b1, 1'b0);
            checks++;
            if (dut_o() !== 5'b00000)
                $display("[TB] FAIL expiry_idle[%0d]: got %b expected %b", j, dut_o(), 5'b0);
            else
                passes++;
        end
        // cnt must have been cleared: a fresh hold needs the full count again
        cycle(1'b0, 1'b1);
        for (int k = 0; k < LONG_T; k++) begin
            cycle(1'b1, 1'b1);
            checks++;
            if (dut_o() !== exp_o)
                $display("[TB] FAIL expiry_rehold tick%0d: got %b expected %b", k + 1, dut_o(), exp_o);
            else
                passes++;
        end
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
    endtask

    task automatic test_repeat();
        int rpt_seen;
        int n_ticks;
        int exp_rpts;
        rpt_seen = 0;
        n_ticks  = REPEAT ? LONG_T + 3 * RPT_T : LONG_T + 50;
        exp_rpts = REPEAT ? 3 : 0;
        cycle(1'b0, 1'b1);
        for (int k = 0; k < n_ticks; k++) begin
            cycle(1'b1, 1'b1);
            rpt_seen += bus.rpt;
            checks++;
            if (dut_o() !== exp_o)
                $display("[TB] FAIL repeat tick%0d: got %b expected %b", k + 1, dut_o(), exp_o);
            else
                passes++;
            cycle(1'b0, 1'b1);
            rpt_seen += bus.rpt;
        end
        checks++;
        if (rpt_seen != exp_rpts)
            $display("[TB] FAIL repeat_count: got %0d expected %0d", rpt_seen, exp_rpts);
        else
            passes++;
        cycle(1'b1, 1'b0);
        checks++;
        if (dut_o() !== 5'b01000)
            $display("[TB] FAIL repeat_release: got %b expected %b", dut_o(), 5'b01000);
        else
            passes++;
        cycle(1'b0, 1'b0);
    endtask

    task automatic test_async_reset_mid_hold();
        cycle(1'b0, 1'b1);
        for (int k = 0; k < LONG_T + 1; k++) cycle(1'b1, 1'b1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_o() !== 5'b0)
            $display("[TB] FAIL async_reset: got %b expected %b", dut_o(), 5'b0);
        else
            passes++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1);
            checks++;
            if (dut_o() !== exp_o)
                $display("[TB] FAIL after_async_reset[%0d]: got %b expected %b", i, dut_o(), exp_o);
            else
                passes++;
        end
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
    endtask

    task automatic test_glitch();
        logic [4:0] seq [3];
        seq[0] = 5'b10001;
        seq[1] = 5'b01000;
        seq[2] = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, i == 0);
            checks++;
            if (dut_o() !== seq[i] || dut_o() !== exp_o)
                $display("[TB] FAIL glitch[%0d]: got %b expected %b", i, dut_o(), seq[i]);
            else
                passes++;
        end
    endtask

    task automatic test_random();
        logic l;
        logic t;
        l = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) l = ~l;
            t = ($urandom_range(0, 3) == 0);
            cycle(t, l);
            checks++;
            if (dut_o() !== exp_o)
                $display("[TB] FAIL random[%0d]: got %b expected %b", i, dut_o(), exp_o);
            else
                passes++;
        end
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_reset_level_high();
        test_long_press();
        test_release_on_expiry();
        test_repeat();
        test_async_reset_mid_hold();
        test_glitch();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 Parameter LONG_TICKS, default 100: number of tick pulses the key must stay held before the long-press event; legal range 1..255.
REQ-002 Parameter RPT_TICKS, default 20: ticks between auto-repeat events once in long-press; legal range 1..255.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 tick  input  1  one-clk-wide timebase strobe, period of several ms.
REQ-006 level  input  1  debounced key level, already synchronous to clk; 1 = pressed.
REQ-007 press  output  1  one-clk pulse on key-down.
REQ-008 rel  output  1  one-clk pulse on key-up.
REQ-009 long  output  1  one-clk pulse when the hold reaches LONG_TICKS.
REQ-010 rpt  output  1  one-clk auto-repeat pulse during long-press.
REQ-011 held  output  1  level, high while state is not IDLE.

Function
REQ-012 States: IDLE, DOWN, LONG; 8-bit tick counter cnt.
REQ-013 IDLE with level=1: next state DOWN, cnt<=0, press=1 in the following cycle; tick is ignored in IDLE.
REQ-014 DOWN with level=1 and tick=1: if cnt+1==LONG_TICKS go to LONG, cnt<=0, long=1 next cycle; otherwise cnt<=cnt+1.
REQ-015 LONG with level=1 and tick=1: if cnt+1==RPT_TICKS then cnt<=0 and rpt=1 next cycle, else cnt<=cnt+1 (only with KEY_EVENT_REPEAT_EN).
REQ-016 DOWN or LONG with level=0: go to IDLE, cnt<=0, rel=1 next cycle.
REQ-017 Release has priority over a simultaneous tick expiry: no long/rpt pulse in the release cycle.
REQ-018 press, rel, long and rpt are registered, mutually exclusive, and never high for two consecutive cycles.
REQ-019 Latency: each pulse is high in exactly the cycle after the clk edge that takes the transition.
REQ-020 held is high exactly when state is DOWN or LONG.
REQ-021 cnt never wraps: it is cleared on reaching the terminal count and on every state change.
REQ-022 A 1-cycle level glitch in IDLE still yields press then rel; filtering is the upstream debouncer's job.

Reset
REQ-023 rst_n=0 immediately forces state=IDLE, cnt=0, and press=rel=long=rpt=held=0.
REQ-024 Reset asserted mid-hold emits no rel pulse.
REQ-025 After deassertion with level already 1, press fires on the first clk edge that samples level=1.

Configuration
REQ-026 Macro KEY_EVENT_REPEAT_EN compiled in: REQ-015 is active and rpt pulses every RPT_TICKS ticks while in LONG.
REQ-027 Macro KEY_EVENT_REPEAT_EN absent: rpt is tied to 0, cnt holds at 0 in LONG, RPT_TICKS is unused, and all other behaviour is identical.

Verification
REQ-028 Reset with level=1 held, then release rst_n -> press=1 for one cycle on the first edge, held=1; no rel.
REQ-029 LONG_TICKS=4, level=1, 4 ticks spaced 10 clks -> long pulses exactly once, the cycle after the 4th tick edge; no pulse after the 3rd tick.
REQ-030 With REPEAT_EN, LONG_TICKS=2, RPT_TICKS=3, 11 ticks held -> long after tick 2, rpt after ticks 5, 8 and 11, then release gives rel=1 and held=0.
REQ-031 LONG_TICKS=4, level falls in the same cycle as the 4th tick -> rel=1 and long never pulses; state IDLE, cnt=0.
REQ-032 Without REPEAT_EN, 50 ticks held after long -> rpt stays 0 throughout; release still gives one rel pulse.
REQ-033 rst_n pulsed low while in LONG -> all outputs 0 asynchronously (before the next clk), no rel; press on the next edge if level is still 1.
